// File: rtl/keypad_scan_fifo.sv
// ROWS x COLS matrix keypad scanner: frame debounce, key encoding and a show-ahead key FIFO.
// Define KEYPAD_AUTOREPEAT_EN to re-push a held key after REPEAT_DELAY frames, then every REPEAT_RATE.
module keypad_scan_fifo #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned KEY_W        = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE     = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned REPEAT_DELAY = 30,
  parameter int unsigned REPEAT_RATE  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS-1:0]               row,
  output logic [COLS-1:0]               col,
  output logic [KEY_W-1:0]              key_code,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int unsigned CW  = $clog2(COLS);
  localparam int unsigned DW  = $clog2(SCAN_DIV);
  localparam int unsigned RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned BW  = $clog2(DEBOUNCE + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNW = AW + 1;

  typedef enum logic [1:0] {ResNone, ResKey, ResMulti} res_e;

  logic [ROWS-1:0]  row_s1, row_s2;
  logic [CW-1:0]    col_idx_q;
  logic [DW-1:0]    dwell_q;
  logic             dwell_end, frame_end;
  logic [1:0]       frm_hits_q, col_hits, sum_hits;
  logic [KEY_W-1:0] frm_key_q, col_key, sum_key;
  logic [RW-1:0]    col_row;
  logic [2:0]       hit_sum;
  res_e             res_kind, prev_kind_q, prev_kind_d, stb_kind_q, stb_kind_d;
  logic [KEY_W-1:0] res_key, prev_key_q, prev_key_d, stb_key_q, stb_key_d;
  logic [BW-1:0]    db_cnt_q, db_cnt_d;
  logic             changed, push_q, push_d;
  logic [KEY_W-1:0] push_key_q, push_key_d;
  logic [KEY_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNW-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0] head_q, head_d;
  logic             ovf_q, ovf_d, full, pop, wr_en;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RPMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RPW   = $clog2(RPMAX + 1);
  logic [RPW-1:0] rep_q, rep_d;
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY[0], REPEAT_RATE[0]};
`endif

  assign dwell_end = (dwell_q == DW'(SCAN_DIV - 1));
  assign frame_end = dwell_end && (col_idx_q == CW'(COLS - 1));
  assign col       = ~(COLS'(1) << col_idx_q);

  // Low rows seen in the current column, folded into the running frame tally.
  always_comb begin
    col_hits = 2'd0;
    col_row  = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!row_s2[r]) begin
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
        col_row = RW'(r);
      end
    end
    col_key  = KEY_W'(32'(col_row) * COLS + 32'(col_idx_q));
    hit_sum  = {1'b0, frm_hits_q} + {1'b0, col_hits};
    sum_hits = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
    sum_key  = (col_hits == 2'd1) ? col_key : frm_key_q;
    res_kind = (sum_hits == 2'd0) ? ResNone : (sum_hits == 2'd1) ? ResKey : ResMulti;
    res_key  = (sum_hits == 2'd1) ? sum_key : '0;
  end

  always_comb begin
    prev_kind_d = prev_kind_q;
    prev_key_d  = prev_key_q;
    db_cnt_d    = db_cnt_q;
    stb_kind_d  = stb_kind_q;
    stb_key_d   = stb_key_q;
    push_d      = 1'b0;
    push_key_d  = push_key_q;
    changed     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_d       = rep_q;
`endif
    if (frame_end) begin
      prev_kind_d = res_kind;
      prev_key_d  = res_key;
      if (res_kind == prev_kind_q && res_key == prev_key_q) begin
        db_cnt_d = (db_cnt_q == BW'(DEBOUNCE)) ? db_cnt_q : db_cnt_q + BW'(1);
      end else begin
        db_cnt_d = BW'(1);
      end
      changed = (db_cnt_d == BW'(DEBOUNCE)) &&
                !(res_kind == stb_kind_q && res_key == stb_key_q);
      if (changed) begin
        stb_kind_d = res_kind;
        stb_key_d  = res_key;
        if (res_kind == ResKey) begin
          push_d     = 1'b1;
          push_key_d = res_key;
        end
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      if (changed) begin
        rep_d = RPW'(REPEAT_DELAY);
      end else if (stb_kind_q == ResKey) begin
        if (rep_q <= RPW'(1)) begin
          push_d     = 1'b1;
          push_key_d = stb_key_q;
          rep_d      = RPW'(REPEAT_RATE);
        end else begin
          rep_d = rep_q - RPW'(1);
        end
      end
`endif
    end
  end

  assign full  = (cnt_q == CNW'(FIFO_DEPTH));
  assign pop   = (cnt_q != '0) && key_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign wr_en = push_q && (!full || pop);

  always_comb begin
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    cnt_d    = cnt_q;
    head_d   = head_q;
    ovf_d    = ovf_q;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CNW'(1);
      2'b01:   cnt_d = cnt_q - CNW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (cnt_d != '0) begin
      head_d = (wr_en && wr_ptr_q == rd_ptr_d) ? push_key_q : mem[rd_ptr_d];
    end
    if (ovf_clr) ovf_d = 1'b0;
    if (push_q && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= push_key_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1      <= '1;
      row_s2      <= '1;
      col_idx_q   <= '0;
      dwell_q     <= '0;
      frm_hits_q  <= '0;
      frm_key_q   <= '0;
      prev_kind_q <= ResNone;
      prev_key_q  <= '0;
      db_cnt_q    <= '0;
      stb_kind_q  <= ResNone;
      stb_key_q   <= '0;
      push_q      <= 1'b0;
      push_key_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      head_q      <= '0;
      ovf_q       <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      row_s1 <= row;
      row_s2 <= row_s1;
      if (dwell_end) begin
        dwell_q    <= '0;
        col_idx_q  <= frame_end ? '0 : col_idx_q + CW'(1);
        frm_hits_q <= frame_end ? 2'd0 : sum_hits;
        frm_key_q  <= frame_end ? '0 : sum_key;
      end else begin
        dwell_q <= dwell_q + DW'(1);
      end
      prev_kind_q <= prev_kind_d;
      prev_key_q  <= prev_key_d;
      db_cnt_q    <= db_cnt_d;
      stb_kind_q  <= stb_kind_d;
      stb_key_q   <= stb_key_d;
      push_q      <= push_d;
      push_key_q  <= push_key_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      head_q      <= head_d;
      ovf_q       <= ovf_d;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign key_code   = head_q;
  assign key_valid  = (cnt_q != '0);
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Directed bench for keypad_scan_fifo: a keypad model drives rows from a pressed-key mask.
// Stimulus changes on frame boundaries so every frame sees one clean key pattern.
module tb_keypad_scan_fifo;

  localparam int ROWS = 4, COLS = 4, KEY_W = 4, SCAN_DIV = 4, DEBOUNCE = 3, FIFO_DEPTH = 4;
  localparam int FRAME = COLS * SCAN_DIV;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [ROWS-1:0]  row;
  logic [COLS-1:0]  col;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready = 1'b0;
  logic [2:0]       fifo_count;
  logic             overflow;
  logic             ovf_clr = 1'b0;
  logic [15:0]      pressed = '0;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [15:0] keys;
    int          frames;
    logic        ready;
    logic        clr;
    int          count;
    logic [3:0]  code;
    logic        ovf;
  } vec_t;

  vec_t vecs [22];

  keypad_scan_fifo #(
    .ROWS(ROWS), .COLS(COLS), .KEY_W(KEY_W), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
    .FIFO_DEPTH(FIFO_DEPTH), .REPEAT_DELAY(2), .REPEAT_RATE(1)
  ) dut (
    .clk(clk), .rst(rst), .row(row), .col(col), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  // A row reads low when any pressed key on it sits in a column being driven low.
  always_comb begin
    row = '1;
    for (int r = 0; r < ROWS; r++) row[r] = ~|(pressed[r*COLS +: COLS] & ~col);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      pressed   = vecs[i].keys;
      key_ready = vecs[i].ready;
      ovf_clr   = vecs[i].clr;
      repeat (vecs[i].frames * FRAME) @(negedge clk);
      check($sformatf("v%0d_count", i), 32'(fifo_count), 32'(vecs[i].count));
      check($sformatf("v%0d_valid", i), 32'(key_valid), 32'(vecs[i].count != 0));
      check($sformatf("v%0d_code", i), 32'(key_code), 32'(vecs[i].code));
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
    end
    key_ready = 1'b0;
    ovf_clr   = 1'b0;
  endtask

`ifdef KEYPAD_AUTOREPEAT_EN
  int n_pop = 0;
  always @(posedge clk) if (!rst && key_valid && key_ready) n_pop++;
`endif

  initial begin
    //           keys      fr  rdy   clr   cnt code  ovf
    vecs[0]  = '{16'h0200, 5, 1'b0, 1'b0, 1, 4'd9, 1'b0};  // clean press of key 9
    vecs[1]  = '{16'h0200, 4, 1'b0, 1'b0, 1, 4'd9, 1'b0};  // still held: no second push
    vecs[2]  = '{16'h0000, 5, 1'b1, 1'b0, 0, 4'd9, 1'b0};  // release + pop, code holds
    vecs[3]  = '{16'h0020, 1, 1'b0, 1'b0, 0, 4'd9, 1'b0};  // one-frame glitch
    vecs[4]  = '{16'h0000, 1, 1'b0, 1'b0, 0, 4'd9, 1'b0};
    vecs[5]  = '{16'h0020, 4, 1'b0, 1'b0, 1, 4'd5, 1'b0};  // held long enough
    vecs[6]  = '{16'h0000, 5, 1'b1, 1'b0, 0, 4'd5, 1'b0};
    vecs[7]  = '{16'h8001, 5, 1'b0, 1'b0, 0, 4'd5, 1'b0};  // keys 0 and 15: multi
    vecs[8]  = '{16'h0001, 5, 1'b0, 1'b0, 1, 4'd0, 1'b0};  // release 15 -> push 0
    vecs[9]  = '{16'h0000, 5, 1'b1, 1'b0, 0, 4'd0, 1'b0};
    vecs[10] = '{16'h0002, 4, 1'b0, 1'b0, 1, 4'd1, 1'b0};
    vecs[11] = '{16'h0004, 4, 1'b0, 1'b0, 2, 4'd1, 1'b0};
    vecs[12] = '{16'h0008, 4, 1'b0, 1'b0, 3, 4'd1, 1'b0};
    vecs[13] = '{16'h0010, 4, 1'b0, 1'b0, 4, 4'd1, 1'b0};
    vecs[14] = '{16'h0020, 4, 1'b0, 1'b0, 4, 4'd1, 1'b1};  // key 5 dropped
    vecs[15] = '{16'h0000, 4, 1'b0, 1'b0, 4, 4'd1, 1'b1};
    vecs[16] = '{16'h0000, 1, 1'b0, 1'b1, 0, 4'd4, 1'b0};  // ovf_clr after drain
    vecs[17] = '{16'h0100, 4, 1'b0, 1'b0, 1, 4'd8, 1'b0};
    vecs[18] = '{16'h0200, 4, 1'b0, 1'b0, 2, 4'd8, 1'b0};
    vecs[19] = '{16'h0400, 4, 1'b0, 1'b0, 3, 4'd8, 1'b0};
    vecs[20] = '{16'h0800, 4, 1'b0, 1'b0, 4, 4'd8, 1'b0};
    vecs[21] = '{16'h0000, 4, 1'b0, 1'b0, 4, 4'd8, 1'b0};

    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'h0000000e);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_col", 32'(col), 32'h0000000e);
    @(negedge clk);
    rst = 1'b0;
    check("dwell0_col", 32'(col), 32'h0000000e);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("dwell%0d_col", i), 32'(col), 32'h0000000e);
    end
    @(negedge clk);
    check("col1", 32'(col), 32'h0000000d);

    do_reset();

`ifdef KEYPAD_AUTOREPEAT_EN
    key_ready = 1'b1;
    pressed   = 16'h0080;
    repeat (10 * FRAME) @(negedge clk);
    pressed = '0;
    repeat (6 * FRAME) @(negedge clk);
    check("repeat_pushes", 32'(n_pop), 32'd9);
    check("repeat_code", 32'(key_code), 32'd7);
    check("repeat_empty", 32'(fifo_count), 32'd0);
`else
    run_vectors(0, 15);

    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain%0d_code", i), 32'(key_code), 32'(i));
      check($sformatf("drain%0d_valid", i), 32'(key_valid), 32'd1);
      key_ready = 1'b1;
      @(negedge clk);
      key_ready = 1'b0;
    end
    check("drained_count", 32'(fifo_count), 32'd0);
    check("drained_valid", 32'(key_valid), 32'd0);
    check("drained_code", 32'(key_code), 32'd4);
    check("drained_ovf", 32'(overflow), 32'd1);
    repeat (FRAME - 4) @(negedge clk);

    run_vectors(16, 21);

    // Full FIFO: pop lands in the same cycle as the push of key 12.
    pressed = 16'h1000;
    repeat (3 * FRAME) @(negedge clk);
    check("full_pre_count", 32'(fifo_count), 32'd4);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("full_pp_count", 32'(fifo_count), 32'd4);
    check("full_pp_code", 32'(key_code), 32'd9);
    check("full_pp_ovf", 32'(overflow), 32'd0);
    repeat (FRAME - 1) @(negedge clk);
    pressed = '0;
    repeat (4 * FRAME) @(negedge clk);

    // Dropped push of key 13 coincides with ovf_clr: the flag must stay set.
    pressed = 16'h2000;
    repeat (3 * FRAME) @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("clr_vs_drop_ovf", 32'(overflow), 32'd1);
    check("clr_vs_drop_count", 32'(fifo_count), 32'd4);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    repeat (FRAME - 2) @(negedge clk);
    pressed = '0;
    repeat (4 * FRAME) @(negedge clk);
    key_ready = 1'b1;
    repeat (4) @(negedge clk);
    key_ready = 1'b0;
    check("empty2_count", 32'(fifo_count), 32'd0);
    check("empty2_code", 32'(key_code), 32'd12);
    repeat (FRAME - 4) @(negedge clk);

    // Single entry: pop of key 14 and push of key 3 in the same cycle.
    pressed = 16'h4000;
    repeat (4 * FRAME) @(negedge clk);
    check("one_count", 32'(fifo_count), 32'd1);
    check("one_code", 32'(key_code), 32'd14);
    pressed = '0;
    repeat (4 * FRAME) @(negedge clk);
    pressed = 16'h0008;
    repeat (3 * FRAME) @(negedge clk);
    check("one_pre_code", 32'(key_code), 32'd14);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    check("one_pp_count", 32'(fifo_count), 32'd1);
    check("one_pp_valid", 32'(key_valid), 32'd1);
    check("one_pp_code", 32'(key_code), 32'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
